// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and
// the sizing helper for the bit counter.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One spare bit over clog2 keeps WIDTH=1 at a legal 1-bit counter.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the serial adder: operands and start in,
// busy/done and the held result out.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/fa_bit.sv
// Single-bit full adder; the whole datapath of the serial adder.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per cycle LSB first,
// sequenced by an IDLE/ADD/DONE controller around a single fa_bit.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             step;
  logic             last;
  logic             fa_s;
  logic             fa_co;

  fa_bit u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  // Sum bits enter at the MSB so after WIDTH steps bit 0 sits at the LSB.
  assign sum_nxt = (sum_r >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ADD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Carry flop is working state; cout_r is the published copy so a new
  // accepted start does not disturb the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      carry  <= bus.cin;
      cnt    <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= fa_co;
      cout_r <= fa_co;
      sum_r  <= sum_nxt;
      cnt    <= cnt + CW'(1);
    end
  end

  assign bus.busy = (state == ADD);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboarded bench for serial_add_ctrl at WIDTH 8, 1 and 32.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8))  bus8 ();
  serial_add_ctrl_if #(.WIDTH(1))  bus1 ();
  serial_add_ctrl_if #(.WIDTH(32)) bus32 ();

  serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_add_ctrl #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  serial_add_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int done8  = 0;
  logic [63:0] q8[$];
  logic [63:0] q1[$];
  logic [63:0] q32[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (bus8.done === 1'b1) begin
      done8++;
      if (q8.size() == 0) chk("w8_unexpected_done", 64'(1), 64'(0));
      else chk("w8_result", 64'({bus8.cout, bus8.sum}), q8.pop_front());
    end
    if (bus1.done === 1'b1) begin
      if (q1.size() == 0) chk("w1_unexpected_done", 64'(1), 64'(0));
      else chk("w1_result", 64'({bus1.cout, bus1.sum}), q1.pop_front());
    end
    if (bus32.done === 1'b1) begin
      if (q32.size() == 0) chk("w32_unexpected_done", 64'(1), 64'(0));
      else chk("w32_result", 64'({bus32.cout, bus32.sum}), q32.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 transaction; inj>0 re-pulses start (a=b=1) in that ADD cycle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input int inj);
    int lat = 0;
    int bsy = 0;
    bit seen = 1'b0;
    bus8.a = a; bus8.b = b; bus8.cin = c; bus8.start = 1'b1;
    q8.push_back(64'(a) + 64'(b) + 64'(c));
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      end
      if (inj > 0 && lat == inj) begin
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01;
      end
      if (inj > 0 && lat == inj + 1) bus8.start = 1'b0;
      @(negedge clk);
      if (bus8.busy === 1'b1) bsy++;
      if (bus8.done === 1'b1) seen = 1'b1;
    end
    chk("w8_latency", 64'(lat), 64'(9));
    chk("w8_busy_cycles", 64'(bsy), 64'(8));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int prev;
    int cnt;
    bus8.start = 0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 0;
    bus1.start = 0;  bus1.a = '0;  bus1.b = '0;  bus1.cin = 0;
    bus32.start = 0; bus32.a = '0; bus32.b = '0; bus32.cin = 0;
    #1;
    chk("rst_busy", 64'(bus8.busy), 64'(0));
    chk("rst_done", 64'(bus8.done), 64'(0));
    chk("rst_sum_cout", 64'({bus8.cout, bus8.sum}), 64'(0));
    chk("rst_state", 64'(dut8.state), 64'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    run8(8'h5A, 8'h33, 1'b0, 0);
    idle(3);
    chk("hold_sum", 64'(bus8.sum), 64'h8D);
    chk("hold_cout", 64'(bus8.cout), 64'(0));
    run8(8'hFF, 8'h01, 1'b0, 0);
    idle(1);
    run8(8'hFF, 8'h00, 1'b1, 0);
    idle(1);

    d0 = done8;
    run8(8'h5A, 8'h33, 1'b0, 3);
    idle(12);
    chk("ignored_start_dones", 64'(done8 - d0), 64'(1));

    // Start held high; fresh operands presented in each DONE cycle.
    bus8.a = 8'hC3; bus8.b = 8'h7E; bus8.cin = 1'b1; bus8.start = 1'b1;
    q8.push_back(64'(8'hC3) + 64'(8'h7E) + 64'(1));
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (bus8.done !== 1'b1 && cnt < 30);
      chk("b2b_done_seen", 64'(bus8.done), 64'(1));
      if (k > 0) chk("b2b_interval", 64'(cyc - prev), 64'(9));
      prev = cyc;
      if (k < 3) begin
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
        q8.push_back(64'(bus8.a) + 64'(bus8.b) + 64'(bus8.cin));
      end else begin
        bus8.start = 1'b0;
      end
    end
    idle(2);

    // Abort mid-ADD with an asynchronous reset.
    bus8.a = 8'h5A; bus8.b = 8'h33; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_abort_busy", 64'(bus8.busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus8.busy), 64'(0));
    chk("abort_done", 64'(bus8.done), 64'(0));
    chk("abort_sum_cout", 64'({bus8.cout, bus8.sum}), 64'(0));
    chk("abort_state", 64'(dut8.state), 64'(IDLE));
    chk("abort_cnt", 64'(dut8.cnt), 64'(0));
    chk("abort_carry", 64'(dut8.carry), 64'(0));
    d0 = done8;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(12);
    chk("abort_no_done", 64'(done8 - d0), 64'(0));
    run8(8'h10, 8'h20, 1'b0, 0);
    idle(2);

    fork
      begin
        repeat (100) begin
          run8(8'($urandom), 8'($urandom), 1'($urandom), 0);
          idle(1);
        end
      end
      begin
        repeat (1000) begin
          bus1.a = 1'($urandom); bus1.b = 1'($urandom); bus1.cin = 1'($urandom);
          bus1.start = 1'b1;
          q1.push_back(64'(bus1.a) + 64'(bus1.b) + 64'(bus1.cin));
          @(posedge clk);
          #1 bus1.start = 1'b0;
          cnt = 0;
          do begin
            @(negedge clk);
            cnt++;
          end while (bus1.done !== 1'b1 && cnt < 10);
          if (bus1.done !== 1'b1) chk("w1_timeout", 64'(0), 64'(1));
          else if (cnt != 2) chk("w1_latency", 64'(cnt), 64'(2));
        end
      end
      begin
        int c32 = 0;
        repeat (1000) begin
          bus32.a = $urandom; bus32.b = $urandom; bus32.cin = 1'($urandom);
          bus32.start = 1'b1;
          q32.push_back(64'(bus32.a) + 64'(bus32.b) + 64'(bus32.cin));
          @(posedge clk);
          #1 bus32.start = 1'b0;
          c32 = 0;
          do begin
            @(negedge clk);
            c32++;
          end while (bus32.done !== 1'b1 && c32 < 40);
          if (bus32.done !== 1'b1) chk("w32_timeout", 64'(0), 64'(1));
        end
      end
    join
    idle(3);
    chk("w8_queue_drained", 64'(q8.size()), 64'(0));
    chk("w1_queue_drained", 64'(q1.size()), 64'(0));
    chk("w32_queue_drained", 64'(q32.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
